// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave transmitter: FSM state encoding and
// the default frame width.
package spi_pkg;

  localparam int SPI_WORD_W = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi_tx_state_e;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input bit.
module spi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift the raw input through STAGES flops; cleared on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ff <= '0;
    else       ff <= (ff << 1) | STAGES'(d);
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_slave_tx.sv
// SPI slave (mode 0, MSB first) with a one-entry transmit holding register.
// sclk/cs/mosi are synchronized into clk; miso changes after sclk falls,
// mosi is sampled when sclk rises.
// Optional feature: define SPI_SLAVE_TX_ECHO_EN to send the last received
// word when no response word has been written for a frame.
module spi_slave_tx
  import spi_pkg::*;
#(
  parameter int WIDTH       = SPI_WORD_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             cs,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  spi_tx_state_e    state, state_nxt;
  logic             sclk_s, cs_s, mosi_s;
  logic             sclk_q, cs_q;
  logic             sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [WIDTH-1:0] tx_shift, rx_shift, hold_data, fill;
  logic             hold_full;
  logic [CW-1:0]    bit_cnt;
  logic             load, last_bit;

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (.clk(clk), .reset(reset), .d(sclk), .q(sclk_s));
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs   (.clk(clk), .reset(reset), .d(cs),   .q(cs_s));
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (.clk(clk), .reset(reset), .d(mosi), .q(mosi_s));

  // Previous synchronized levels for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_q <= 1'b0;
      cs_q   <= 1'b0;
    end else begin
      sclk_q <= sclk_s;
      cs_q   <= cs_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_rise   = cs_s & ~cs_q;
  assign cs_fall   = ~cs_s & cs_q;

  assign load     = (state == IDLE) && cs_rise;
  assign last_bit = (state == SHIFT) && !cs_fall && sclk_rise && (bit_cnt == CW'(WIDTH - 1));
  assign tx_ready = !hold_full;

`ifdef SPI_SLAVE_TX_ECHO_EN
  assign fill = rx_data;
`else
  assign fill = '0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state: an early cs drop aborts, the last rising edge completes.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_rise) state_nxt = SHIFT;
      SHIFT:   if (cs_fall) state_nxt = IDLE;
               else if (last_bit) state_nxt = DONE;
      DONE:    if (!cs_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: miso only driven while shifting.
  always_comb begin
    busy = (state != IDLE);
    miso = (state == SHIFT) ? tx_shift[WIDTH-1] : 1'b0;
  end

  // Holding register: a write on the load cycle wins over the clear, so it
  // is kept for the following frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else begin
      if (load) hold_full <= 1'b0;
      if (tx_valid && tx_ready) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end
    end
  end

  // Shift registers, bit counter and the one-cycle status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_shift  <= '0;
      rx_shift  <= '0;
      bit_cnt   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: if (cs_rise) begin
          tx_shift <= hold_full ? hold_data : fill;
          rx_shift <= '0;
          bit_cnt  <= '0;
        end
        SHIFT: if (cs_fall) begin
          tx_shift  <= '0;
          rx_shift  <= '0;
          bit_cnt   <= '0;
          frame_err <= 1'b1;
        end else begin
          if (sclk_rise) begin
            rx_shift <= {rx_shift[WIDTH-2:0], mosi_s};
            bit_cnt  <= bit_cnt + CW'(1);
          end
          if (last_bit) begin
            rx_data  <= {rx_shift[WIDTH-2:0], mosi_s};
            rx_valid <= 1'b1;
          end
          if (sclk_fall) tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_tx.sv
// Self-checking bench for spi_slave_tx: directed frame table, hand-written
// corner sequences (abort, holding-register priority, mid-frame reset) and
// randomized frames checked against a word-level model.
module tb_spi_slave_tx;

  localparam int W = 12;
`ifdef SPI_SLAVE_TX_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic         clk = 1'b0, reset = 1'b1;
  logic         sclk = 1'b0, cs = 1'b0, mosi = 1'b0;
  logic         miso, tx_ready, rx_valid, frame_err, busy;
  logic [W-1:0] tx_data = '0, rx_data;
  logic         tx_valid = 1'b0;

  int checks = 0, failures = 0;
  int rxv_cnt = 0, ferr_cnt = 0;

  // Word-level model: holding register and last received word.
  bit           m_full = 1'b0;
  logic [W-1:0] m_hold = '0, m_rx = '0;

  spi_slave_tx #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid)  rxv_cnt++;
    if (frame_err) ferr_cnt++;
  end

  typedef struct {
    bit           do_wr;
    logic [W-1:0] wr;
    logic [W-1:0] mo;
    logic [W-1:0] exp_mi;
    logic [W-1:0] exp_rx;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One write attempt, mirrored into the model.
  task automatic tx_write(input logic [W-1:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    if (!m_full) begin
      m_hold = d;
      m_full = 1'b1;
    end
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Model: word the slave will send in the next frame.
  function automatic logic [W-1:0] mdl_start();
    logic [W-1:0] e;
    if (m_full) begin
      e = m_hold;
      m_full = 1'b0;
    end else begin
      e = ECHO ? m_rx : '0;
    end
    return e;
  endfunction

  // Mode-0 master. stop_at < W ends the frame early (cs drop or reset).
  task automatic spi_frame(input logic [W-1:0] mo, input int stop_at, input bit do_rst,
                           output logic [W-1:0] mi);
    mi = '0;
    @(negedge clk);
    cs = 1'b1;
    cyc(8);
    for (int i = 0; i < W; i++) begin
      if (i == stop_at) begin
        if (do_rst) reset = 1'b1;
        break;
      end
      mosi = mo[W-1-i];
      cyc(4);
      mi[W-1-i] = miso;
      if (i == 0) chk("busy_in_frame", busy, 1);
      sclk = 1'b1;
      cyc(8);
      sclk = 1'b0;
      cyc(4);
    end
    cs   = 1'b0;
    mosi = 1'b0;
    cyc(8);
  endtask

  task automatic full_frame(input string name, input logic [W-1:0] mo, input logic [W-1:0] exp_mi);
    logic [W-1:0] mi;
    int rv0, fe0;
    rv0 = rxv_cnt;
    fe0 = ferr_cnt;
    spi_frame(mo, W, 1'b0, mi);
    m_rx = mo;
    chk({name, "_miso"}, mi, exp_mi);
    chk({name, "_rx_data"}, rx_data, mo);
    chk({name, "_rx_valid_cnt"}, rxv_cnt - rv0, 1);
    chk({name, "_frame_err_cnt"}, ferr_cnt - fe0, 0);
    chk({name, "_busy_after"}, busy, 0);
  endtask

  vec_t tbl[5];

  initial begin
    logic [W-1:0] mi, e, w, mo;
    int rv0, fe0, t;
    bit got;

    tbl[0] = '{1'b1, 12'hA5C, 12'h3F0, 12'hA5C, 12'h3F0};
    tbl[1] = '{1'b0, 12'h000, 12'hFFF, ECHO ? 12'h3F0 : 12'h000, 12'hFFF};
    tbl[2] = '{1'b0, 12'h000, 12'hFFF, ECHO ? 12'hFFF : 12'h000, 12'hFFF};
    tbl[3] = '{1'b1, 12'h5A3, 12'h000, 12'h5A3, 12'h000};
    tbl[4] = '{1'b0, 12'h000, 12'h123, 12'h000, 12'h123};

    // Reset values while reset is held
    cyc(3);
    chk("rst_miso", miso, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_ready", tx_ready, 1);
    reset = 1'b0;
    cyc(3);

    // Directed table
    foreach (tbl[k]) begin
      if (tbl[k].do_wr) begin
        tx_write(tbl[k].wr);
        chk($sformatf("tbl%0d_tx_ready_full", k), tx_ready, 0);
      end
      void'(mdl_start());
      full_frame($sformatf("tbl%0d", k), tbl[k].mo, tbl[k].exp_mi);
      chk($sformatf("tbl%0d_rx_exp", k), rx_data, tbl[k].exp_rx);
    end

    // Early cs drop after 5 bits
    rv0 = rxv_cnt;
    fe0 = ferr_cnt;
    void'(mdl_start());
    spi_frame(12'hABC, 5, 1'b0, mi);
    chk("abort_frame_err_cnt", ferr_cnt - fe0, 1);
    chk("abort_rx_valid_cnt", rxv_cnt - rv0, 0);
    chk("abort_rx_unchanged", rx_data, 12'h123);
    chk("abort_busy", busy, 0);
    e = mdl_start();
    full_frame("after_abort", 12'h123, e);

    // Holding register: second write while full ignored; a write held
    // across the frame start lands for the next frame.
    tx_write(12'h111);
    tx_write(12'h222);
    chk("hold_ignored_ready", tx_ready, 0);
    @(negedge clk);
    tx_data  = 12'h333;
    tx_valid = 1'b1;
    e = mdl_start();
    got = 1'b0;
    fork
      spi_frame(12'h0F0, W, 1'b0, mi);
      begin
        for (int c = 0; c < 200; c++) begin
          @(negedge clk);
          if (tx_ready) begin
            @(negedge clk);
            got = 1'b1;
            break;
          end
        end
        tx_valid = 1'b0;
      end
    join
    chk("hold_write_accepted", got, 1);
    m_hold = 12'h333;
    m_full = 1'b1;
    m_rx   = 12'h0F0;
    chk("hold_frame1_miso", mi, 12'h111);
    e = mdl_start();
    full_frame("hold_frame2", 12'h456, e);
    chk("hold_frame2_exp", e, 12'h333);

    // Reset asserted at bit 7
    tx_write(12'h777);
    rv0 = rxv_cnt;
    fe0 = ferr_cnt;
    spi_frame(12'hDEF, 7, 1'b1, mi);
    chk("mrst_miso", miso, 0);
    chk("mrst_rx_data", rx_data, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_tx_ready", tx_ready, 1);
    reset = 1'b0;
    m_full = 1'b0;
    m_rx   = '0;
    cyc(4);
    chk("mrst_no_rx_valid", rxv_cnt - rv0, 0);
    chk("mrst_no_frame_err", ferr_cnt - fe0, 0);
    e = mdl_start();
    full_frame("after_mrst", 12'h9A5, e);

    // Randomized frames against the model
    for (int r = 0; r < 16; r++) begin
      t = $urandom_range(0, 3);
      if (t != 0) tx_write(W'($urandom));
      if (t == 3) tx_write(W'($urandom));
      chk($sformatf("rnd%0d_tx_ready", r), tx_ready, !m_full);
      mo = W'($urandom);
      e = mdl_start();
      full_frame($sformatf("rnd%0d", r), mo, e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
